// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC gain constant, quarter encoding and arctangent table
package cordic_pkg;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;
    localparam logic [1:0] Q3 = 2'b11;

    // atan(2^-i) as a fraction of the full circle, scaled to 2^32
    localparam logic [31:0] ATAN_LUT [16] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861
    };

    // 1/K rounded to gf fractional bits; the real-to-int cast rounds to nearest
    function automatic int inv_gain(input int gf);
        real r;
        r = 0.6072529;
        for (int i = 0; i < gf; i++) r = r * 2.0;
        return int'(r);
    endfunction

    localparam int INV_GAIN = inv_gain(15);

    // rotator step angle i in units where 2^(aw+1) is the full circle
    function automatic logic [31:0] atan_angle(input logic [3:0] i, input int aw);
        return ATAN_LUT[i] >> (31 - aw);
    endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: registered amplitude pre-scale by 1/K with round-half-up
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int GAIN_FRAC  = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH:0]   a,
    output logic signed [DATA_WIDTH:0]   x
);

    localparam int SW = DATA_WIDTH + GAIN_FRAC + 1;
    localparam logic signed [GAIN_FRAC:0] G    = (GAIN_FRAC+1)'(inv_gain(GAIN_FRAC));
    localparam logic signed [SW-1:0]      HALF = SW'(1) << (GAIN_FRAC - 1);

    logic signed [SW-1:0] sum;
    logic                 unused_frac;

    // |a*G| < 2^(SW-1) since 1/K < 1, so the truncated signed sum is exact
    assign sum         = SW'(a) * SW'(G) + HALF;
    assign unused_frac = ^sum[GAIN_FRAC-1:0];

    // load the rounded product only when the stage holds valid data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            x <= '0;
        else if (en)
            x <= sum[SW-1:GAIN_FRAC];
    end

endmodule

// File: rtl/cordic_prerotator.sv
// cordic_prerotator: phase split into quarter/residual and 1/K amplitude pre-scale; PHASE_ACC_EN adds a phase accumulator
module cordic_prerotator
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int ANGLE_WIDTH = 16,
    parameter int GAIN_FRAC   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic        [ANGLE_WIDTH:0]   phase_i,
    input  logic signed [DATA_WIDTH:0]    amp_i,
    output logic signed [DATA_WIDTH:0]    x_o,
    output logic signed [DATA_WIDTH:0]    y_o,
    output logic signed [ANGLE_WIDTH:0]   z_o,
    output logic        [1:0]             quarter_o,
    output logic                          valid_o
);

    localparam int AW = ANGLE_WIDTH;

    logic        [AW:0]         p;
    logic        [AW:0]         ph_nxt;
    logic signed [DATA_WIDTH:0] a;
    logic                       va;

`ifdef PHASE_ACC_EN
    logic [AW:0] acc;

    assign ph_nxt = acc + phase_i;

    // phase accumulator advances by the tuning word on every valid input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (valid_i)
            acc <= ph_nxt;
    end
`else
    assign ph_nxt = phase_i;
`endif

    // stage A: capture phase and amplitude; valid always shifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p  <= '0;
            a  <= '0;
            va <= 1'b0;
        end else begin
            va <= valid_i;
            if (valid_i) begin
                p <= ph_nxt;
                a <= amp_i;
            end
        end
    end

    // stage B: split phase into quarter and in-quarter residual
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quarter_o <= Q0;
            z_o       <= '0;
            y_o       <= '0;
            valid_o   <= 1'b0;
        end else begin
            valid_o <= va;
            if (va) begin
                quarter_o <= p[AW:AW-1];
                z_o       <= {2'b00, p[AW-2:0]};
                y_o       <= '0;
            end
        end
    end

    cordic_gain_comp #(
        .DATA_WIDTH (DATA_WIDTH),
        .GAIN_FRAC  (GAIN_FRAC)
    ) u_gain (
        .clk (clk),
        .rst (rst),
        .en  (va),
        .a   (a),
        .x   (x_o)
    );

endmodule

// File: tb/tb_cordic_prerotator.sv
// tb_cordic_prerotator: scoreboard bench for cordic_prerotator; PHASE_ACC_EN selects the accumulator vectors
module tb_cordic_prerotator;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               valid_i = 1'b0;
    logic        [16:0] phase_i = '0;
    logic signed [12:0] amp_i = '0;
    logic signed [12:0] x_o, y_o;
    logic signed [16:0] z_o;
    logic        [1:0]  quarter_o;
    logic               valid_o;

    typedef struct { int t; int q; int z; int x; } exp_t;
    exp_t sb[$];
    exp_t last = '{0, 0, 0, 0};
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    cordic_prerotator dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .phase_i   (phase_i),
        .amp_i     (amp_i),
        .x_o       (x_o),
        .y_o       (y_o),
        .z_o       (z_o),
        .quarter_o (quarter_o),
        .valid_o   (valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // monitor: pop on every valid output, otherwise outputs must hold the last item
    always @(negedge clk) begin
        if (valid_o) begin
            if (sb.size() == 0) chk("unexpected_valid_o", 1, 0);
            else begin
                last = sb.pop_front();
                chk("latency", cyc, last.t + 2);
                chk("quarter", quarter_o, last.q);
                chk("z", z_o, last.z);
                chk("x", x_o, last.x);
                chk("y", y_o, 0);
            end
        end else if (rst) begin
            chk("hold_quarter", quarter_o, last.q);
            chk("hold_z", z_o, last.z);
            chk("hold_x", x_o, last.x);
        end
    end

    task automatic issue(input logic [16:0] ph, input int amp, input int q, input int z, input int x, input bit push);
        phase_i = ph;
        amp_i   = 13'(amp);
        valid_i = 1'b1;
        if (push) sb.push_back('{cyc, q, z, x});
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_x", x_o, 0);
        chk("rst_z", z_o, 0);
        chk("rst_quarter", quarter_o, 0);
        chk("rst_y", y_o, 0);
        idle(2);
        rst = 1'b1;
        idle(1);
`ifdef PHASE_ACC_EN
        issue(17'h10000, 2000, 2, 0, 1214, 1);
        issue(17'h10000, 2000, 0, 0, 1214, 1);
        issue(17'h10000, 2000, 2, 0, 1214, 1);
        idle(3);
`else
        issue(17'h08000, 2000, 1, 0, 1214, 1);
        idle(3);
        issue(17'h1FFFF, -4096, 3, 32767, -2487, 1);
        issue(17'h1FFFF, 4095, 3, 32767, 2487, 1);
        idle(3);
        issue(17'h00000, 1, 0, 0, 1, 1);
        issue(17'h08000, -1, 1, 0, -1, 1);
        issue(17'h10000, 2048, 2, 0, 1244, 1);
        issue(17'h18000, -2048, 3, 0, -1244, 1);
        issue(17'h12345, 100, 2, 9029, 61, 1);
        idle(3);
        issue(17'h04000, 10, 0, 16384, 6, 1);
        idle(1);
        issue(17'h17FFF, -10, 2, 32767, -6, 1);
        idle(3);
`endif
        issue(17'h08000, 500, 0, 0, 0, 0);
        issue(17'h10000, 600, 0, 0, 0, 0);
        chk("inflight_valid_o", valid_o, 1);
        rst  = 1'b0;
        last = '{0, 0, 0, 0};
        #1;
        chk("async_rst_valid_o", valid_o, 0);
        chk("async_rst_x", x_o, 0);
        chk("async_rst_z", z_o, 0);
        chk("async_rst_quarter", quarter_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(4);
        issue(17'h08000, 2000, 1, 0, 1214, 1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        idle(2);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
